// File: rtl/gardner_ted_if.sv
`default_nettype none
// ============================================================================
// gardner_ted_if : sample-in / error-out bus of the Gardner timing detector.
// Revision       : 1.0
// ============================================================================
interface gardner_ted_if #(
  parameter int W = 16
);
  logic signed [W-1:0] iData;
  logic signed [W-1:0] qData;
  logic                dataValid;
  logic                strobe;
  logic signed [W-1:0] errData;
  logic                errValid;

  modport master (
    output iData, qData, dataValid, strobe,
    input  errData, errValid
  );

  modport slave (
    input  iData, qData, dataValid, strobe,
    output errData, errValid
  );
endinterface
`default_nettype wire

// File: rtl/gardner_ted.sv
`default_nettype none
// ============================================================================
// gardner_ted : Gardner timing error detector, 2 samples/symbol, saturated Q1.14.
//               Define TED_QCHAN_EN to include the Q-channel term.
// Revision    : 1.0
// ============================================================================
module gardner_ted #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  gardner_ted_if.slave bus
);
  localparam int c_W  = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int c_PW = 2*c_W + 1;
  localparam int c_SW = 2*c_W + 2;

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_HAVE_ON  = 2'd1;
  localparam logic [1:0] c_HAVE_MID = 2'd2;

  localparam logic signed [c_SW-1:0] c_SAT_MAX = {{(c_W+3){1'b0}}, {(c_W-1){1'b1}}};
  localparam logic signed [c_SW-1:0] c_SAT_MIN = {{(c_W+3){1'b1}}, {(c_W-1){1'b0}}};

  logic [1:0] r_state;
  logic       w_acc_on;
  logic       w_acc_mid;
  logic       w_launch;
  logic       w_store_mid;

  assign w_acc_on    = bus.dataValid &  bus.strobe;
  assign w_acc_mid   = bus.dataValid & ~bus.strobe;
  assign w_launch    = w_acc_on  && (r_state == c_HAVE_MID);
  assign w_store_mid = w_acc_mid && (r_state != c_IDLE);

  // Every on-time sample lands in HAVE_ON; a midpoint only counts once an on-time exists.
  always_ff @(posedge clk) begin
    if (!rst_n)           r_state <= c_IDLE;
    else if (w_acc_on)    r_state <= c_HAVE_ON;
    else if (w_store_mid) r_state <= c_HAVE_MID;
  end

  logic                  r_launch;
  logic                  r_s1_valid;
  logic signed [c_W-1:0] r_prev_i;
  logic signed [c_W-1:0] r_lprev_i;
  logic signed [c_W-1:0] r_mid_i;
  logic signed [c_W:0]   r_s1_diff_i;
  logic signed [c_W-1:0] r_s1_mid_i;

  // r_prev_i already holds cur_on after the launch edge; r_lprev_i keeps the old prev_on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_launch    <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_prev_i    <= '0;
      r_lprev_i   <= '0;
      r_mid_i     <= '0;
      r_s1_diff_i <= '0;
      r_s1_mid_i  <= '0;
    end else begin
      r_launch   <= w_launch;
      r_s1_valid <= r_launch;
      if (w_acc_on)    r_prev_i  <= bus.iData;
      if (w_launch)    r_lprev_i <= r_prev_i;
      if (w_store_mid) r_mid_i   <= bus.iData;
      if (r_launch) begin
        r_s1_diff_i <= (c_W+1)'(r_lprev_i) - (c_W+1)'(r_prev_i);
        r_s1_mid_i  <= r_mid_i;
      end
    end
  end

  logic signed [c_PW-1:0] w_prod_i;
  logic signed [c_SW-1:0] w_sum;
  logic signed [c_SW-1:0] w_shift;
  logic signed [c_W-1:0]  w_sat;

  assign w_prod_i = c_PW'(r_s1_diff_i) * c_PW'(r_s1_mid_i);

`ifdef TED_QCHAN_EN
  logic signed [c_W-1:0]  r_prev_q;
  logic signed [c_W-1:0]  r_lprev_q;
  logic signed [c_W-1:0]  r_mid_q;
  logic signed [c_W:0]    r_s1_diff_q;
  logic signed [c_W-1:0]  r_s1_mid_q;
  logic signed [c_PW-1:0] w_prod_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_q    <= '0;
      r_lprev_q   <= '0;
      r_mid_q     <= '0;
      r_s1_diff_q <= '0;
      r_s1_mid_q  <= '0;
    end else begin
      if (w_acc_on)    r_prev_q  <= bus.qData;
      if (w_launch)    r_lprev_q <= r_prev_q;
      if (w_store_mid) r_mid_q   <= bus.qData;
      if (r_launch) begin
        r_s1_diff_q <= (c_W+1)'(r_lprev_q) - (c_W+1)'(r_prev_q);
        r_s1_mid_q  <= r_mid_q;
      end
    end
  end

  assign w_prod_q = c_PW'(r_s1_diff_q) * c_PW'(r_s1_mid_q);
  assign w_sum    = c_SW'(w_prod_i) + c_SW'(w_prod_q);
`else
  logic w_unused_q;
  assign w_unused_q = ^bus.qData;
  assign w_sum      = c_SW'(w_prod_i);
`endif

  assign w_shift = w_sum >>> DEC_WIDTH;

  always_comb begin
    w_sat = w_shift[c_W-1:0];
    if (w_shift > c_SAT_MAX)      w_sat = c_SAT_MAX[c_W-1:0];
    else if (w_shift < c_SAT_MIN) w_sat = c_SAT_MIN[c_W-1:0];
  end

  logic signed [c_W-1:0] r_err;
  logic                  r_err_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err       <= '0;
      r_err_valid <= 1'b0;
    end else begin
      r_err_valid <= r_s1_valid;
      if (r_s1_valid) r_err <= w_sat;
    end
  end

  assign bus.errData  = r_err;
  assign bus.errValid = r_err_valid;
endmodule
`default_nettype wire
